fifo_uart_tx: RTL and testbench

Downstream drain stage for the 8-bit byte FIFO. It pops one byte at a time through the FIFO read port (rd_en / buf_out / buf_empty) and serialises each byte as an asynchronous UART frame on tx. It sits between the FIFO and the board pin, and provides frame-done and frame-count status for software and debug.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/fifo_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding,
// data width and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } tx_state_t;

    localparam int DATA_BITS = 8;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last count of each bit period. clear has priority and restarts the period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    assign count = count_reg;
    assign tick  = enable && (count_reg == LAST);

    // Period counter: wraps to zero after the last count so consecutive bits
    // in the same state line up without an explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= tick ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and serialises each byte as a UART
// frame (start, 8 data bits LSB first, optional parity, 1 or 2 stop bits).
// Every output comes straight from a register.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frames_sent
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

    tx_state_t      state_reg, state_next;
    logic [7:0]     shift_reg, shift_next;
    logic           parity_reg, parity_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic           tx_reg, tx_next;
    logic           rd_en_reg, rd_en_next;
    logic           busy_reg;
    logic           frame_done_reg, frame_done_next;
    logic [15:0]    frames_sent_reg;

    logic [CNT_W-1:0] baud_count;
    logic             baud_tick;
    logic             baud_enable;
    logic             baud_clear;
    logic             can_fetch;

    assign can_fetch   = tx_enable && !fifo_empty;
    assign baud_enable = (state_reg == START) || (state_reg == DATA) ||
                         (state_reg == PARITY) || (state_reg == STOP);
    assign baud_clear  = (state_next != state_reg);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (baud_clear),
        .enable (baud_enable),
        .count  (baud_count),
        .tick   (baud_tick)
    );

    // Next-state and next-output logic; outputs are precomputed from the
    // state being entered so the registered versions line up with it.
    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        bit_idx_next    = bit_idx_reg;
        rd_en_next      = 1'b0;
        frame_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (can_fetch) begin
                    state_next = FETCH;
                    rd_en_next = 1'b1;
                end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                shift_next   = fifo_data;
                parity_next  = parity_bit(fifo_data, PARITY_ODD != 0);
                bit_idx_next = '0;
                state_next   = START;
            end
            START: begin
                if (baud_tick) state_next = DATA;
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_reg == LAST_DATA_IDX) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) state_next = STOP;
            end
            STOP: begin
                // Flag one cycle ahead so frame_done is high on the last clk.
                frame_done_next = (bit_idx_reg == LAST_STOP_IDX) && (baud_count == PRE_LAST);
                if (baud_tick) begin
                    if (bit_idx_reg == LAST_STOP_IDX) begin
                        bit_idx_next = '0;
                        if (can_fetch) begin
                            state_next = FETCH;
                            rd_en_next = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level for the state being entered; high whenever not in a timed bit.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            bit_idx_reg     <= '0;
            tx_reg          <= 1'b1;
            rd_en_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
            frames_sent_reg <= '0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            bit_idx_reg    <= bit_idx_next;
            tx_reg         <= tx_next;
            rd_en_reg      <= rd_en_next;
            busy_reg       <= (state_next != IDLE);
            frame_done_reg <= frame_done_next;
            if (frame_done_next) begin
                frames_sent_reg <= frames_sent_reg + 16'd1;
            end
        end
    end

    assign fifo_rd_en  = rd_en_reg;
    assign tx          = tx_reg;
    assign busy        = busy_reg;
    assign frame_done  = frame_done_reg;
    assign frames_sent = frames_sent_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances at CLKS_PER_BIT = 4
//   inst 0: no parity, 1 stop bit
//   inst 1: even parity, 2 stop bits
//   inst 2: odd parity, 1 stop bit
// each fed by its own small registered-output FIFO model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  tx_en = 3'b111;
    logic [2:0]  push_req = 3'b000;
    logic [7:0]  push_byte [3];

    logic [2:0]  empty_w;
    logic [2:0]  rd_w;
    logic [2:0]  tx_w;
    logic [2:0]  busy_w;
    logic [2:0]  fd_w;
    logic [15:0] fs_w [3];
    logic [4:0]  fcnt_w [3];
    int          rd_cnt_w [3];
    int          bad_pop_w [3];
    int          long_w [3];

    int n_chk  = 0;
    int n_fail = 0;
    int exp_frames [3];
    int exp_pops [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        logic [7:0] mem [16];
        logic [4:0] wr_ptr = '0;
        logic [4:0] rd_ptr = '0;
        logic [7:0] dout = '0;
        logic       rd_prev = 1'b0;
        int         rd_cnt = 0;
        int         bad_pop = 0;
        int         long_pulse = 0;

        assign empty_w[gi]   = (wr_ptr == rd_ptr);
        assign fcnt_w[gi]    = wr_ptr - rd_ptr;
        assign rd_cnt_w[gi]  = rd_cnt;
        assign bad_pop_w[gi] = bad_pop;
        assign long_w[gi]    = long_pulse;

        // FIFO model: registered read data, pop on rd_en, flag pops while empty.
        always @(posedge clk) begin
            if (push_req[gi]) begin
                mem[wr_ptr[3:0]] <= push_byte[gi];
                wr_ptr <= wr_ptr + 5'd1;
            end
            if (rd_w[gi]) begin
                rd_cnt <= rd_cnt + 1;
                if (wr_ptr == rd_ptr) begin
                    bad_pop <= bad_pop + 1;
                end else begin
                    dout   <= mem[rd_ptr[3:0]];
                    rd_ptr <= rd_ptr + 5'd1;
                end
            end
            if (rd_w[gi] && rd_prev) long_pulse <= long_pulse + 1;
            rd_prev <= rd_w[gi];
        end

        fifo_uart_tx #(
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    ((gi == 0) ? 0 : 1),
            .PARITY_ODD   ((gi == 2) ? 1 : 0),
            .STOP_BITS    ((gi == 1) ? 2 : 1)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .tx_enable   (tx_en[gi]),
            .fifo_empty  (empty_w[gi]),
            .fifo_data   (dout),
            .fifo_rd_en  (rd_w[gi]),
            .tx          (tx_w[gi]),
            .busy        (busy_w[gi]),
            .frame_done  (fd_w[gi]),
            .frames_sent (fs_w[gi])
        );
    end

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         pen;
        logic       pbit;
        int         nstop;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        push_byte[i] = b;
        push_req[i]  = 1'b1;
        @(negedge clk);
        push_req[i]  = 1'b0;
    endtask

    // Wait (bounded) until the line is low; leaves us on the first START cycle.
    task automatic wait_tx_low(input int i, output logic ok);
        int waited;
        waited = 0;
        while (tx_w[i] !== 1'b0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        ok = (tx_w[i] === 1'b0);
    endtask

    // Compare every clk of one frame against the expected bit sequence, and
    // frame_done against a single pulse on the frame's final clk.
    task automatic check_frame(input int i, input logic [7:0] b, input int pen,
                               input logic pbit, input int nstop);
        logic [11:0] bits;
        int nb, n, bad_tx, bad_fd, first_bad;
        logic ok;
        bits = '0;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int j = 0; j < 8; j++) begin
            bits[nb] = b[j]; nb++;
        end
        if (pen != 0) begin
            bits[nb] = pbit; nb++;
        end
        for (int s = 0; s < nstop; s++) begin
            bits[nb] = 1'b1; nb++;
        end
        wait_tx_low(i, ok);
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL start_timeout inst %0d byte %02h: got tx=%b, expected 0 within 300 clk", i, b, tx_w[i]);
            return;
        end
        n = nb * CPB;
        bad_tx = 0;
        bad_fd = 0;
        first_bad = -1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            if (tx_w[i] !== bits[k / CPB]) begin
                bad_tx++;
                if (first_bad < 0) first_bad = k;
            end
            if (fd_w[i] !== (k == n - 1)) bad_fd++;
        end
        $display("inst %0d frame byte %02h: %0d bits, tx errors %0d (first at clk %0d), frame_done errors %0d",
                 i, b, nb, bad_tx, first_bad, bad_fd);
        chk($sformatf("frame_tx_inst%0d_%02h", i, b), bad_tx, 0);
        chk($sformatf("frame_done_inst%0d_%02h", i, b), bad_fd, 0);
    endtask

    initial begin
        int gap, lows, w;
        logic ok;

        for (int i = 0; i < 3; i++) begin
            exp_frames[i] = 0;
            exp_pops[i]   = 0;
            push_byte[i]  = 8'h00;
        end
        vecs[0] = '{inst: 1, data: 8'h07, pen: 1, pbit: 1'b1, nstop: 2};
        vecs[1] = '{inst: 2, data: 8'h07, pen: 1, pbit: 1'b0, nstop: 1};
        vecs[2] = '{inst: 0, data: 8'hC8, pen: 0, pbit: 1'b0, nstop: 1};
        vecs[3] = '{inst: 1, data: 8'h80, pen: 1, pbit: 1'b1, nstop: 2};
        vecs[4] = '{inst: 2, data: 8'h00, pen: 1, pbit: 1'b1, nstop: 1};
        vecs[5] = '{inst: 0, data: 8'hFF, pen: 0, pbit: 1'b0, nstop: 1};

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tx%0d", i), int'(tx_w[i]), 1);
            chk($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
            chk($sformatf("rst_fd%0d", i), int'(fd_w[i]), 0);
            chk($sformatf("rst_rd%0d", i), int'(rd_w[i]), 0);
            chk($sformatf("rst_fs%0d", i), int'(fs_w[i]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Empty FIFO with tx_enable high: nothing happens
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_w !== 3'b111) lows++;
        end
        $display("idle with empty FIFO: %0d low-line clks", lows);
        chk("empty_tx_idle", lows, 0);
        chk("empty_no_pop", rd_cnt_w[0] + rd_cnt_w[1] + rd_cnt_w[2], 0);

        // Single byte with latency checks
        push(0, 8'h55);
        chk("lat_empty_fell", int'(empty_w[0]), 0);
        chk("lat_rd_c0", int'(rd_w[0]), 0);
        @(negedge clk);
        chk("lat_rd_c1", int'(rd_w[0]), 1);
        @(negedge clk);
        chk("lat_rd_c2", int'(rd_w[0]), 0);
        chk("lat_tx_c2", int'(tx_w[0]), 1);
        @(negedge clk);
        chk("lat_tx_c3", int'(tx_w[0]), 0);
        check_frame(0, 8'h55, 0, 1'b0, 1);
        @(negedge clk);
        exp_frames[0]++;
        exp_pops[0]++;
        chk("single_busy", int'(busy_w[0]), 0);
        chk("single_fs", int'(fs_w[0]), exp_frames[0]);
        chk("single_pops", rd_cnt_w[0], exp_pops[0]);

        // Table of single frames across the parity / stop-bit variants
        for (int v = 0; v < 6; v++) begin
            push(vecs[v].inst, vecs[v].data);
            check_frame(vecs[v].inst, vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].nstop);
            @(negedge clk);
            exp_frames[vecs[v].inst]++;
            exp_pops[vecs[v].inst]++;
            chk($sformatf("vec%0d_busy", v), int'(busy_w[vecs[v].inst]), 0);
            chk($sformatf("vec%0d_fs", v), int'(fs_w[vecs[v].inst]), exp_frames[vecs[v].inst]);
            chk($sformatf("vec%0d_pops", v), rd_cnt_w[vecs[v].inst], exp_pops[vecs[v].inst]);
        end

        // Back-to-back frames with the two-clk FETCH/LOAD gap
        push(0, 8'hA3);
        push(0, 8'h0F);
        check_frame(0, 8'hA3, 0, 1'b0, 1);
        gap = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx_w[0] === 1'b0) break;
            gap++;
        end
        $display("back-to-back gap: %0d high clks", gap);
        chk("b2b_gap", gap, 2);
        check_frame(0, 8'h0F, 0, 1'b0, 1);
        @(negedge clk);
        exp_frames[0] += 2;
        exp_pops[0]   += 2;
        chk("b2b_fs", int'(fs_w[0]), exp_frames[0]);
        chk("b2b_pops", rd_cnt_w[0], exp_pops[0]);
        chk("b2b_busy", int'(busy_w[0]), 0);

        // tx_enable dropped during DATA with a second byte queued
        push(0, 8'h5A);
        push(0, 8'h24);
        wait_tx_low(0, ok);
        chk("drop_start_seen", int'(ok), 1);
        repeat (12) @(negedge clk);
        tx_en[0] = 1'b0;
        w = 0;
        while (busy_w[0] && w < 300) begin
            @(negedge clk);
            w++;
        end
        exp_frames[0]++;
        exp_pops[0]++;
        chk("drop_idle", int'(busy_w[0]), 0);
        chk("drop_fs", int'(fs_w[0]), exp_frames[0]);
        chk("drop_pops", rd_cnt_w[0], exp_pops[0]);
        chk("drop_fifo_left", int'(fcnt_w[0]), 1);
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) lows++;
        end
        $display("disabled with byte queued: %0d active clks", lows);
        chk("drop_held", lows, 0);
        chk("drop_no_pop", rd_cnt_w[0], exp_pops[0]);
        tx_en[0] = 1'b1;
        check_frame(0, 8'h24, 0, 1'b0, 1);
        @(negedge clk);
        exp_frames[0]++;
        exp_pops[0]++;
        chk("resume_fs", int'(fs_w[0]), exp_frames[0]);

        // Asynchronous reset during data bit 3 (0xF0: bit 3 drives the line low)
        push(0, 8'hF0);
        wait_tx_low(0, ok);
        chk("rst_start_seen", int'(ok), 1);
        repeat (17) @(negedge clk);
        chk("rst_bit3_low", int'(tx_w[0]), 0);
        rst = 1'b1;
        #1;
        $display("async reset mid-frame: tx=%b busy=%b frames=%0d", tx_w[0], busy_w[0], fs_w[0]);
        chk("arst_tx", int'(tx_w[0]), 1);
        chk("arst_busy", int'(busy_w[0]), 0);
        chk("arst_fs", int'(fs_w[0]), 0);
        for (int i = 0; i < 3; i++) exp_frames[i] = 0;
        exp_pops[0]++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(0, 8'h96);
        check_frame(0, 8'h96, 0, 1'b0, 1);
        @(negedge clk);
        exp_frames[0]++;
        exp_pops[0]++;
        chk("post_rst_fs", int'(fs_w[0]), exp_frames[0]);

        // frames_sent wrap from 0xFFFF
        force g_inst[0].u_dut.frames_sent_reg = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        release g_inst[0].u_dut.frames_sent_reg;
        @(negedge clk);
        chk("wrap_preload", int'(fs_w[0]), 32'hFFFF);
        push(0, 8'h3C);
        check_frame(0, 8'h3C, 0, 1'b0, 1);
        @(negedge clk);
        exp_pops[0]++;
        chk("wrap_fs", int'(fs_w[0]), 0);

        // FIFO-side protocol over the whole run
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pop_on_empty%0d", i), bad_pop_w[i], 0);
            chk($sformatf("long_rd_pulse%0d", i), long_w[i], 0);
            chk($sformatf("total_pops%0d", i), rd_cnt_w[i], exp_pops[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
